// File: rtl/md_pkg.sv
// md_pkg: multiply/divide unit op encodings, commit kinds and default latencies.
package md_pkg;
   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } md_op_t;
   typedef enum logic [1:0] {K_SET, K_KEEP, K_ADD, K_SUB} md_kind_t;
   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;
endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle HI/LO multiply/divide unit; result computed at accept, committed when the busy count expires.
// Optional madd/msub family enabled by defining MD_UNIT_MADD_EN.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  op,
   input  logic        start,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int CW = $clog2(((MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC) + 1);
   logic [CW-1:0] cnt, cyc;
   logic [63:0] pend, res_n, prod_s, prod_u, acc;
   md_kind_t kind, kind_n;
   logic signed [32:0] sa, sb;
   logic [31:0] sq, sr;
   logic take;
   assign busy   = cnt != '0;
   assign take   = start && !flush && !busy;
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'b0, A} * {32'b0, B};
   // 33-bit signed divide so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing
   assign sa  = {A[31], A};
   assign sb  = {B[31], B};
   assign sq  = 32'(sa / sb);
   assign sr  = 32'(sa % sb);
   assign acc = {HI, LO};
   always_comb begin
      cyc    = '0;
      res_n  = prod_s;
      kind_n = K_SET;
      case (md_op_t'(op))
         OP_MULT:  cyc = CW'(MULT_CYC);
         OP_MULTU: begin
            cyc   = CW'(MULT_CYC);
            res_n = prod_u;
         end
         OP_DIV: begin
            cyc    = CW'(DIV_CYC);
            res_n  = {sr, sq};
            kind_n = (B == '0) ? K_KEEP : K_SET;
         end
         OP_DIVU: begin
            cyc    = CW'(DIV_CYC);
            res_n  = {A % B, A / B};
            kind_n = (B == '0) ? K_KEEP : K_SET;
         end
`ifdef MD_UNIT_MADD_EN
         OP_MADD: begin
            cyc    = CW'(MULT_CYC);
            kind_n = K_ADD;
         end
         OP_MADDU: begin
            cyc    = CW'(MULT_CYC);
            res_n  = prod_u;
            kind_n = K_ADD;
         end
         OP_MSUB: begin
            cyc    = CW'(MULT_CYC);
            kind_n = K_SUB;
         end
         OP_MSUBU: begin
            cyc    = CW'(MULT_CYC);
            res_n  = prod_u;
            kind_n = K_SUB;
         end
`endif
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         HI   <= '0;
         LO   <= '0;
         pend <= '0;
         kind <= K_SET;
      end else if (busy) begin
         cnt <= cnt - 1'b1;
         // accumulate forms read HI/LO as they stand at commit
         if (cnt == CW'(1)) begin
            if (kind == K_SET) {HI, LO} <= pend;
            if (kind == K_ADD) {HI, LO} <= acc + pend;
            if (kind == K_SUB) {HI, LO} <= acc - pend;
         end
      end else if (take) begin
         cnt  <= cyc;
         pend <= res_n;
         kind <= kind_n;
         if (op == OP_MTHI) HI <= A;
         if (op == OP_MTLO) LO <= A;
      end
   end
endmodule
